// File: rtl/am_err_monitor.sv
// am_err_monitor: error characterisation for a 16x16 approximate multiplier.
// Over a window of N = 2**SAMPLES_LOG2 accepted samples, this block accumulates the
// error count, the sum of the error distance (ED = |a*b - approx|) and the maximum ED.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            pulse that opens a measurement window (honoured in IDLE/DONE only)
//   in_valid         sample present on a/b/approx
//   in_ready         block accepts a sample this cycle
//   a, b, approx     operands and the approximate product under test
//   busy             window in progress (RUN or DRAIN)
//   stat_valid       statistics final, held until next start or rst
//   err_count        samples with ED != 0
//   ed_sum, ed_max   ED sum and maximum over the window
module am_err_monitor #(
  parameter int unsigned SAMPLES_LOG2 = 10,
  parameter int unsigned SUM_W        = 32 + SAMPLES_LOG2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             a,
  input  logic [15:0]             b,
  input  logic [31:0]             approx,
  output logic                    busy,
  output logic                    stat_valid,
  output logic [SAMPLES_LOG2:0]   err_count,
  output logic [SUM_W-1:0]        ed_sum,
  output logic [31:0]             ed_max
);

  localparam int unsigned CntW = SAMPLES_LOG2 + 1;
  localparam logic [CntW-1:0] NSamp   = {1'b1, {SAMPLES_LOG2{1'b0}}};
  localparam logic [CntW-1:0] LastIdx = NSamp - CntW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   acc_cnt_q;
  logic              clear;
  logic              accept;

  // Stage 1: registered sample
  logic              s1_v_q;
  logic [15:0]       s1_a_q, s1_b_q;
  logic [31:0]       s1_ap_q;
  // Stage 2: registered error distance
  logic              s2_v_q;
  logic [31:0]       s2_ed_q;
  logic              s2_nz_q;
  // Stage 3: accumulators
  logic [CntW-1:0]   cnt_q;
  logic [SUM_W-1:0]  sum_q;
  logic [31:0]       max_q;

  logic [31:0]       exact;
  logic [31:0]       ed;

  assign in_ready = (state_q == StRun) && (acc_cnt_q < NSamp);
  assign accept   = in_valid && in_ready;

  assign exact = 32'(s1_a_q) * 32'(s1_b_q);
  assign ed    = (exact >= s1_ap_q) ? (exact - s1_ap_q) : (s1_ap_q - exact);

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          clear   = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (accept && (acc_cnt_q == LastIdx)) state_d = StDrain;
      end
      StDrain: begin
        // Pipe empty means the final accumulation landed on the previous edge.
        if (!s1_v_q && !s2_v_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_cnt_q <= '0;
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_ap_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_ed_q   <= '0;
      s2_nz_q   <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      max_q     <= '0;
    end else begin
      state_q <= state_d;

      if (clear)       acc_cnt_q <= '0;
      else if (accept) acc_cnt_q <= acc_cnt_q + CntW'(1);

      s1_v_q <= accept;
      if (accept) begin
        s1_a_q  <= a;
        s1_b_q  <= b;
        s1_ap_q <= approx;
      end

      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_ed_q <= ed;
        s2_nz_q <= (ed != 32'd0);
      end

      // clear only fires in IDLE/DONE where the pipe is empty, so it never races s2_v_q.
      if (clear) begin
        cnt_q <= '0;
        sum_q <= '0;
        max_q <= '0;
      end else if (s2_v_q) begin
        cnt_q <= cnt_q + CntW'(s2_nz_q);
        sum_q <= sum_q + SUM_W'(s2_ed_q);
        if (s2_ed_q > max_q) max_q <= s2_ed_q;
      end
    end
  end

  assign busy       = (state_q == StRun) || (state_q == StDrain);
  assign stat_valid = (state_q == StDone);
  assign err_count  = cnt_q;
  assign ed_sum     = sum_q;
  assign ed_max     = max_q;

endmodule

// File: tb/tb_am_err_monitor.sv
module tb_am_err_monitor;

  localparam int unsigned L2 = 2;
  localparam int unsigned SW = 32 + L2;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, busy, stat_valid;
  logic [15:0]   a, b;
  logic [31:0]   approx, ed_max;
  logic [L2:0]   err_count;
  logic [SW-1:0] ed_sum;

  am_err_monitor #(.SAMPLES_LOG2(L2), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx(approx), .busy(busy), .stat_valid(stat_valid),
    .err_count(err_count), .ed_sum(ed_sum), .ed_max(ed_max)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] a; logic [15:0] b; logic [31:0] ap;} samp_t;
  // gap: 0 back-to-back, 1 bubble every other cycle, 2 random bubbles
  typedef struct {int first; int gap; bit poke; logic [2:0] cnt; logic [33:0] sum;
                  logic [31:0] mx; int lat;} win_t;

  samp_t smp[12];
  win_t  wt[6];
  samp_t cur[NS];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: statistics straight from the definition of ED over the window.
  task automatic model(output logic [2:0] c, output logic [33:0] s, output logic [31:0] m);
    longint ex, d;
    c = 0; s = 0; m = 0;
    for (int i = 0; i < NS; i++) begin
      ex = longint'(cur[i].a) * longint'(cur[i].b);
      d  = (ex >= longint'(cur[i].ap)) ? ex - longint'(cur[i].ap) : longint'(cur[i].ap) - ex;
      if (d != 0) c++;
      s += 34'(d);
      if (d > longint'(m)) m = 32'(d);
    end
  endtask

  // Runs one window from the current cur[] contents; returns measured latency.
  task automatic run_win(input string tag, input int gap, input bit poke, output int lat,
                         output int lat_last);
    int idx = 0;
    bit bub = 0, done = 0, poked = 0;
    logic rdy;
    lat = 0; lat_last = 0;
    @(negedge clk) start = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      start = poke && (idx == NS) && !poked;
      if (start) poked = 1;
      if (idx < NS && !bub) begin
        in_valid = 1'b1; a = cur[idx].a; b = cur[idx].b; approx = cur[idx].ap;
      end else begin
        in_valid = 1'b0; a = $urandom; b = $urandom; approx = $urandom;
      end
      rdy = in_ready;
      @(posedge clk);
      if (lat > 0 || (in_valid && rdy)) lat++;
      if (in_valid && rdy) begin
        idx++;
        if (idx == NS) lat_last = lat;
      end
      bub = (gap == 1) ? (in_valid && rdy) : (gap == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      #1;
      if (in_valid && rdy && idx == NS) chk({tag, "_ready_low"}, 64'(in_ready), 64'd0);
      if (stat_valid) done = 1;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    int lat, lat_last;
    logic [2:0] mc; logic [33:0] ms; logic [31:0] mm;
    logic [31:0] ex;

    smp[0]  = '{a: 16'd3,      b: 16'd5,      ap: 32'd15};
    smp[1]  = '{a: 16'd7,      b: 16'd9,      ap: 32'd63};
    smp[2]  = '{a: 16'hFFFF,   b: 16'd2,      ap: 32'h1FFFE};
    smp[3]  = '{a: 16'd100,    b: 16'd200,    ap: 32'd20000};
    smp[4]  = '{a: 16'hFFFF,   b: 16'hFFFF,   ap: 32'hFFFE0000};
    smp[5]  = '{a: 16'h0100,   b: 16'h0100,   ap: 32'h00010000};
    smp[6]  = '{a: 16'd2,      b: 16'd3,      ap: 32'd0};
    smp[7]  = '{a: 16'd0,      b: 16'd0,      ap: 32'h10};
    smp[8]  = '{a: 16'd0,      b: 16'd5,      ap: 32'hFFFFFFFF};
    smp[9]  = '{a: 16'd1,      b: 16'd1,      ap: 32'd0};
    smp[10] = '{a: 16'd0,      b: 16'd0,      ap: 32'hFFFFFFFF};
    smp[11] = '{a: 16'd2,      b: 16'd2,      ap: 32'd4};

    wt[0] = '{first: 0, gap: 0, poke: 0, cnt: 3'd0, sum: 34'd0, mx: 32'd0, lat: 7};
    wt[1] = '{first: 4, gap: 0, poke: 0, cnt: 3'd3, sum: 34'd23, mx: 32'd16, lat: 7};
    wt[2] = '{first: 4, gap: 1, poke: 0, cnt: 3'd3, sum: 34'd23, mx: 32'd16, lat: 10};
    wt[3] = '{first: -1, gap: 0, poke: 0, cnt: 3'd4, sum: 34'h3FFF80004, mx: 32'hFFFE0001,
              lat: 7};
    wt[4] = '{first: 8, gap: 0, poke: 0, cnt: 3'd3, sum: 34'h1FFFFFFFF, mx: 32'hFFFFFFFF,
              lat: 7};
    wt[5] = '{first: 4, gap: 0, poke: 1, cnt: 3'd3, sum: 34'd23, mx: 32'd16, lat: 7};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; approx = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_stat_valid", 64'(stat_valid), 0);
    chk("rst_err_count", 64'(err_count), 0);
    chk("rst_ed_sum", 64'(ed_sum), 0);
    chk("rst_ed_max", 64'(ed_max), 0);

    // in_valid while IDLE is not accepted
    @(negedge clk) begin rst = 1'b0; in_valid = 1'b1; a = 16'd9; b = 16'd9; approx = 32'd0; end
    repeat (2) @(negedge clk) chk("idle_in_ready", 64'(in_ready), 0);
    in_valid = 1'b0;

    foreach (wt[w]) begin
      string tag;
      tag = $sformatf("win%0d", w);
      for (int i = 0; i < NS; i++)
        cur[i] = (wt[w].first < 0) ? '{a: 16'hFFFF, b: 16'hFFFF, ap: 32'd0}
                                   : smp[wt[w].first + i];
      run_win(tag, wt[w].gap, wt[w].poke, lat, lat_last);
      chk({tag, "_lat"}, 64'(lat), 64'(wt[w].lat));
      chk({tag, "_err_count"}, 64'(err_count), 64'(wt[w].cnt));
      chk({tag, "_ed_sum"}, 64'(ed_sum), 64'(wt[w].sum));
      chk({tag, "_ed_max"}, 64'(ed_max), 64'(wt[w].mx));
    end

    // DONE holds steady, then a second start clears and reopens the window
    repeat (3) @(negedge clk);
    chk("done_hold_stat", 64'(stat_valid), 1);
    chk("done_hold_sum", 64'(ed_sum), 23);
    start = 1'b1;
    @(posedge clk); #1;
    chk("restart_stat_valid", 64'(stat_valid), 0);
    chk("restart_err_count", 64'(err_count), 0);
    chk("restart_ed_sum", 64'(ed_sum), 0);
    chk("restart_ed_max", 64'(ed_max), 0);
    chk("restart_in_ready", 64'(in_ready), 1);
    @(negedge clk) start = 1'b0;

    // Random windows against the model (window already open from the restart)
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NS; i++) begin
        cur[i].a = (r == 0) ? 16'hFFFF : 16'($urandom);
        cur[i].b = 16'($urandom);
        ex = 32'(cur[i].a) * 32'(cur[i].b);
        case ($urandom_range(0, 2))
          0: cur[i].ap = ex;
          1: cur[i].ap = ex ^ 32'($urandom_range(0, 255));
          default: cur[i].ap = $urandom;
        endcase
      end
      model(mc, ms, mm);
      run_win($sformatf("rnd%0d", r), 2, 0, lat, lat_last);
      chk($sformatf("rnd%0d_lat", r), 64'(lat), 64'(lat_last + 3));
      chk($sformatf("rnd%0d_err_count", r), 64'(err_count), 64'(mc));
      chk($sformatf("rnd%0d_ed_sum", r), 64'(ed_sum), 64'(ms));
      chk($sformatf("rnd%0d_ed_max", r), 64'(ed_max), 64'(mm));
    end

    // rst two samples into a window discards partial results
    @(negedge clk) start = 1'b1;
    @(negedge clk) begin start = 1'b0; in_valid = 1'b1; a = 16'd2; b = 16'd3; approx = 0; end
    @(negedge clk) begin a = 16'd0; b = 16'd0; approx = 32'h10; end
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk);
    chk("partial_err_count", 64'(err_count), 1);
    chk("partial_ed_sum", 64'(ed_sum), 6);
    chk("partial_busy", 64'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_in_ready", 64'(in_ready), 0);
    chk("midrst_err_count", 64'(err_count), 0);
    chk("midrst_ed_sum", 64'(ed_sum), 0);
    chk("midrst_ed_max", 64'(ed_max), 0);
    @(negedge clk) begin rst = 1'b0; in_valid = 1'b1; a = 16'd7; b = 16'd7; approx = 0; end
    repeat (3) @(negedge clk) chk("midrst_no_accept", 64'(in_ready), 0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_still_zero", 64'(ed_sum), 0);

    // start and rst together: rst wins
    for (int i = 0; i < NS; i++) cur[i] = smp[4 + i];
    run_win("pre_rs", 0, 0, lat, lat_last);
    @(negedge clk) begin start = 1'b1; rst = 1'b1; end
    @(posedge clk); #1;
    chk("rst_start_busy", 64'(busy), 0);
    chk("rst_start_stat", 64'(stat_valid), 0);
    chk("rst_start_ed_sum", 64'(ed_sum), 0);
    @(negedge clk) begin start = 1'b0; rst = 1'b0; end
    @(negedge clk);
    chk("rst_start_idle", 64'(in_ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
